// File: rtl/dac_pkg.sv
// Shared definitions for the Wishbone SPI DAC transmitter: register map,
// STATUS/CONTROL bit positions, DAC command-word layout and serializer states.
package dac_pkg;

  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_DATA    = 8'h04;
  localparam logic [7:0] ADDR_CONTROL = 8'h08;
  localparam logic [7:0] ADDR_RATE    = 8'h0C;
  localparam logic [7:0] ADDR_THRESH  = 8'h10;

  localparam int ST_BUSY      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_UNDERRUN  = 3;
  localparam int ST_OVERFLOW  = 4;
  localparam int ST_LATE      = 5;
  localparam int ST_LEVEL_LSB = 8;

  localparam int CTL_ENABLE    = 0;
  localparam int CTL_GAIN2X    = 1;
  localparam int CTL_CLR_FLAGS = 2;
  localparam int CTL_FLUSH     = 3;

  // MCP4921 command nibble: channel A, unbuffered, gain select (active low), active.
  localparam int FRAME_AB     = 15;
  localparam int FRAME_BUF    = 14;
  localparam int FRAME_GA_N   = 13;
  localparam int FRAME_SHDN_N = 12;

  localparam int SAMPLE_W   = 12;
  localparam int LEVEL_W    = 5;
  localparam int THRESH_RST = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    SHIFT,
    HOLD,
    LATCH
  } dac_state_t;

  function automatic logic [15:0] build_frame(input logic [SAMPLE_W-1:0] sample,
                                              input logic gain2x);
    logic [15:0] f;
    f               = '0;
    f[FRAME_AB]     = 1'b0;
    f[FRAME_BUF]    = 1'b0;
    f[FRAME_GA_N]   = ~gain2x;
    f[FRAME_SHDN_N] = 1'b1;
    f[SAMPLE_W-1:0] = sample;
    return f;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with occupancy level. A push while full is dropped
// even if a pop happens in the same cycle; a pop while empty is ignored.
module dac_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, so
  // the array can map onto plain RAM/register-file resources.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/wb_dac_tx.sv
// Wishbone slave buffering 12-bit samples and streaming them to an MCP4921-style
// SPI DAC at a programmable rate. Define DAC_FIFO_IRQ_EN for the low-water irq.
module wb_dac_tx
  import dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int RATE_RST   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        irq
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic ack_r, access, wr_en;
  logic [7:0]  adr;
  logic [31:0] dat_r, rd_data;
  logic wr_data, wr_ctrl, clr_flags, flush;

  logic        enable, gain2x;
  logic [15:0] rate, eff_rate, rate_cnt;
  logic        tick;
  logic        underrun, overflow, late;

  logic [SAMPLE_W-1:0] fifo_dout, last_sample, sample;
  logic [LW-1:0]       fifo_level;
  logic [LEVEL_W-1:0]  level5;
  logic                fifo_full, fifo_empty, pop;

  dac_state_t state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             div_last, sclk_hi;
  logic [3:0]       bit_cnt;
  logic [15:0]      shreg;

  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i[31:16]};

  // Wishbone: one wait state, side effects on the edge where ack_r sets.
  assign adr       = wb_adr_i[7:0];
  assign access    = wb_stb_i & wb_cyc_i & ~ack_r;
  assign wr_en     = access & wb_we_i;
  assign wr_data   = wr_en & (adr == ADDR_DATA);
  assign wr_ctrl   = wr_en & (adr == ADDR_CONTROL);
  assign clr_flags = wr_ctrl & wb_dat_i[CTL_CLR_FLAGS];
  assign flush     = wr_ctrl & wb_dat_i[CTL_FLUSH];
  assign wb_ack_o  = wb_stb_i & wb_cyc_i & ack_r;
  assign wb_dat_o  = wb_ack_o ? dat_r : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_r <= 1'b0;
      dat_r <= '0;
    end else begin
      ack_r <= access;
      if (access) dat_r <= wb_we_i ? '0 : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      gain2x <= 1'b0;
      rate   <= 16'(RATE_RST);
    end else begin
      if (wr_ctrl) begin
        enable <= wb_dat_i[CTL_ENABLE];
        gain2x <= wb_dat_i[CTL_GAIN2X];
      end
      if (wr_en && adr == ADDR_RATE) rate <= wb_dat_i[15:0];
    end
  end

`ifdef DAC_FIFO_IRQ_EN
  logic [LEVEL_W-1:0] thresh;
  logic               irq_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh <= LEVEL_W'(THRESH_RST);
      irq_r  <= 1'b0;
    end else begin
      if (wr_en && adr == ADDR_THRESH) thresh <= wb_dat_i[LEVEL_W-1:0];
      irq_r <= enable & (level5 <= thresh);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (adr)
      ADDR_STATUS: begin
        rd_data[ST_BUSY]                      = busy;
        rd_data[ST_EMPTY]                     = fifo_empty;
        rd_data[ST_FULL]                      = fifo_full;
        rd_data[ST_UNDERRUN]                  = underrun;
        rd_data[ST_OVERFLOW]                  = overflow;
        rd_data[ST_LATE]                      = late;
        rd_data[ST_LEVEL_LSB +: LEVEL_W]      = level5;
      end
      ADDR_CONTROL: begin
        rd_data[CTL_ENABLE] = enable;
        rd_data[CTL_GAIN2X] = gain2x;
      end
      ADDR_RATE: rd_data[15:0] = rate;
`ifdef DAC_FIFO_IRQ_EN
      ADDR_THRESH: rd_data[LEVEL_W-1:0] = thresh;
`endif
      default: ;
    endcase
  end

  dac_sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (wr_data),
    .din   (wb_dat_i[SAMPLE_W-1:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign level5 = LEVEL_W'(fifo_level);
  assign sample = fifo_empty ? last_sample : fifo_dout;

  // Sample-rate tick: RATE of 0 behaves as 1, counter parks at reload when disabled.
  assign eff_rate = (rate == '0) ? 16'd1 : rate;
  assign tick     = enable & (rate_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_cnt <= '0;
    end else if (!enable || rate_cnt == '0) begin
      rate_cnt <= eff_rate - 16'd1;
    end else begin
      rate_cnt <= rate_cnt - 16'd1;
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun    <= 1'b0;
      overflow    <= 1'b0;
      late        <= 1'b0;
      last_sample <= '0;
    end else begin
      underrun <= (pop & fifo_empty) | (underrun & ~clr_flags);
      overflow <= (wr_data & fifo_full) | (overflow & ~clr_flags);
      late     <= (tick & busy) | (late & ~clr_flags);
      if (pop && !fifo_empty) last_sample <= fifo_dout;
    end
  end

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tick) state_nxt = LOAD;
      LOAD:  state_nxt = SETUP;
      SETUP: if (div_last) state_nxt = SHIFT;
      SHIFT: if (div_last && !sclk_hi && bit_cnt == 4'd15) state_nxt = HOLD;
      HOLD:  if (div_last) state_nxt = LATCH;
      LATCH: if (div_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dac_cs_n   = 1'b1;
    dac_sclk   = 1'b0;
    dac_sdi    = 1'b0;
    dac_ldac_n = 1'b1;
    busy       = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: busy = 1'b0;
      LOAD: begin
        dac_cs_n = 1'b0;
        pop      = 1'b1;
      end
      SETUP, HOLD: begin
        dac_cs_n = 1'b0;
        dac_sdi  = shreg[15];
      end
      SHIFT: begin
        dac_cs_n = 1'b0;
        dac_sclk = sclk_hi;
        dac_sdi  = shreg[15];
      end
      LATCH: dac_ldac_n = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  // Each SHIFT period is CLK_DIV high then CLK_DIV low; data moves on the fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk_hi <= 1'b0;
      shreg   <= '0;
    end else begin
      div_cnt <= (state == IDLE || state == LOAD || div_last) ? '0 : div_cnt + DIV_W'(1);
      case (state)
        LOAD: begin
          shreg   <= build_frame(sample, gain2x);
          bit_cnt <= '0;
          sclk_hi <= 1'b0;
        end
        SETUP: if (div_last) sclk_hi <= 1'b1;
        SHIFT: begin
          if (div_last) begin
            if (sclk_hi) begin
              sclk_hi <= 1'b0;
              if (bit_cnt != 4'd15) shreg <= {shreg[14:0], 1'b0};
            end else begin
              sclk_hi <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dac_tx.sv
// Directed bench for wb_dac_tx: register access, DAC frame shape and timing,
// FIFO limits, sticky flags, rate overrun and (when built in) the FIFO irq.
module tb_wb_dac_tx;

  localparam int CLK_DIV = 4;
`ifdef DAC_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb_i, wb_cyc_i, wb_we_i;
  logic        wb_ack_o;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  wb_dac_tx #(
    .FIFO_DEPTH(16),
    .CLK_DIV   (CLK_DIV),
    .RATE_RST  (1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_ack_o   (wb_ack_o),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .dac_cs_n   (dac_cs_n),
    .dac_sclk   (dac_sclk),
    .dac_sdi    (dac_sdi),
    .dac_ldac_n (dac_ldac_n),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset    = 1'b1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wb_access(input logic we, input logic [7:0] a, input logic [31:0] din,
                           output logic [31:0] dout, output int waits);
    @(posedge clk);
    #1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = {24'h0, a};
    wb_dat_i = din;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (wb_ack_o !== 1'b1 && waits < 10);
    dout = wb_dat_o;
    if (wb_ack_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wb_ack addr=%h: no ack after %0d cycles, required ack", a, waits);
    end
    @(posedge clk);
    #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unused_d;
    int unused_w;
    wb_access(1'b1, a, d, unused_d, unused_w);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    int unused_w;
    wb_access(1'b0, a, 32'h0, d, unused_w);
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: read %h, required %h", name, d, exp);
    end
  endtask

  // Waits for cs_n to fall, then records the bits seen on sclk rising edges,
  // the number of busy cycles and ldac_n-low cycles until busy drops.
  task automatic capture_frame(output logic [15:0] frame, output int busy_n,
                               output int ldac_cnt, output int start);
    int w;
    logic prev;
    frame = '0;
    busy_n = 0;
    ldac_cnt = 0;
    start = 0;
    w = 0;
    @(negedge clk);
    while (dac_cs_n !== 1'b0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (dac_cs_n !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL frame_start: cs_n=%b after %0d cycles, required 0", dac_cs_n, w);
      return;
    end
    start = cyc;
    prev = 1'b0;
    w = 0;
    while (busy === 1'b1 && w < 400) begin
      if (!prev && dac_sclk === 1'b1) frame = {frame[14:0], dac_sdi};
      if (dac_ldac_n === 1'b0) ldac_cnt++;
      busy_n++;
      prev = dac_sclk;
      @(negedge clk);
      w++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL frame_end: busy=%b after %0d cycles, required 0", busy, w);
    end
  endtask

  task automatic frame_check(input string name, input logic [15:0] f, input logic [15:0] exp_f,
                             input int bn, input int ln);
    checks++;
    if (f !== exp_f) begin
      errors++;
      $display("FAIL %s_bits: got %h, required %h", name, f, exp_f);
    end
    checks++;
    if (bn !== 35 * CLK_DIV + 1) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d, required %0d", name, bn, 35 * CLK_DIV + 1);
    end
    checks++;
    if (ln !== CLK_DIV) begin
      errors++;
      $display("FAIL %s_ldac_len: got %0d, required %0d", name, ln, CLK_DIV);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int waits;
    do_reset();
    @(negedge clk);
    checks++;
    if ({dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, irq, wb_ack_o} !== 7'b1001000) begin
      errors++;
      $display("FAIL reset_outputs: cs,sclk,sdi,ldac,busy,irq,ack=%b, required 1001000",
               {dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, irq, wb_ack_o});
    end
    wb_access(1'b0, 8'h00, 32'h0, d, waits);
    checks++;
    if (d !== 32'h0000_0002) begin
      errors++;
      $display("FAIL reset_status: read %h, required 00000002", d);
    end
    checks++;
    if (waits !== 2) begin
      errors++;
      $display("FAIL ack_wait_state: ack on negedge %0d, required 2", waits);
    end
    @(negedge clk);
    checks++;
    if (wb_dat_o !== 32'h0 || wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_bus: dat=%h ack=%b, required 0 and 0", wb_dat_o, wb_ack_o);
    end
    read_check("reset_rate", 8'h0C, 32'd1000);
    read_check("reset_control", 8'h08, 32'h0);
    read_check("reset_thresh", 8'h10, IRQ_EN ? 32'd4 : 32'd0);
    read_check("data_reads_zero", 8'h04, 32'h0);
    read_check("unmapped_read", 8'h40, 32'h0);
    wb_write(8'h40, 32'hFFFF_FFFF);
    read_check("unmapped_write_ignored", 8'h00, 32'h0000_0002);
  endtask

  task automatic test_frame();
    logic [15:0] f;
    int bn, ln, st, t0;
    wb_write(8'h0C, 32'd200);
    read_check("rate_rw", 8'h0C, 32'd200);
    wb_write(8'h04, 32'h0000_0ABC);
    wb_write(8'h08, 32'h1);
    t0 = cyc;
    capture_frame(f, bn, ln, st);
    checks++;
    if (st - t0 > 200 || st - t0 < 190) begin
      errors++;
      $display("FAIL first_tick_latency: %0d cycles, required 190..200", st - t0);
    end
    frame_check("frame_abc", f, 16'h3ABC, bn, ln);
    wb_write(8'h04, 32'h0000_0123);
    wb_write(8'h08, 32'h3);
    capture_frame(f, bn, ln, st);
    frame_check("frame_gain2x", f, 16'h1123, bn, ln);
    wb_write(8'h08, 32'h0);
    read_check("frame_status", 8'h00, 32'h0000_0002);
  endtask

  task automatic test_underrun();
    logic [15:0] f;
    int bn, ln, st;
    do_reset();
    wb_write(8'h0C, 32'd200);
    wb_write(8'h08, 32'h1);
    capture_frame(f, bn, ln, st);
    frame_check("frame_underrun", f, 16'h3000, bn, ln);
    read_check("underrun_set", 8'h00, 32'h0000_000A);
    wb_write(8'h08, 32'h5);
    read_check("clr_keeps_enable", 8'h08, 32'h1);
    read_check("underrun_cleared", 8'h00, 32'h0000_0002);
    wb_write(8'h08, 32'h0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) wb_write(8'h04, 32'h100 + i);
    read_check("fifo_full_no_ovf", 8'h00, 32'h0000_1004);
    wb_write(8'h04, 32'h0000_0FFF);
    read_check("fifo_overflow", 8'h00, 32'h0000_1014);
    wb_write(8'h08, 32'h8);
    read_check("flush_empty", 8'h00, 32'h0000_0012);
    read_check("flush_reads_zero", 8'h08, 32'h0);
  endtask

  task automatic test_back_to_back_late();
    logic [15:0] f1, f2, f3;
    int bn1, bn2, bn3, ln1, ln2, ln3, st1, st2, st3;
    do_reset();
    wb_write(8'h0C, 32'd100);
    wb_write(8'h04, 32'h111);
    wb_write(8'h04, 32'h222);
    wb_write(8'h04, 32'h333);
    wb_write(8'h08, 32'h1);
    capture_frame(f1, bn1, ln1, st1);
    capture_frame(f2, bn2, ln2, st2);
    capture_frame(f3, bn3, ln3, st3);
    wb_write(8'h08, 32'h0);
    frame_check("late_f1", f1, 16'h3111, bn1, ln1);
    frame_check("late_f2", f2, 16'h3222, bn2, ln2);
    frame_check("late_f3", f3, 16'h3333, bn3, ln3);
    checks++;
    if (st2 - st1 !== 200 || st3 - st2 !== 200) begin
      errors++;
      $display("FAIL late_spacing: gaps %0d and %0d, required 200 and 200", st2 - st1, st3 - st2);
    end
    read_check("late_flag", 8'h00, 32'h0000_0022);
  endtask

  task automatic test_irq();
    logic [15:0] f;
    int bn, ln, st;
    do_reset();
    wb_write(8'h10, 32'd9);
    read_check("thresh_rw", 8'h10, IRQ_EN ? 32'd9 : 32'd0);
    wb_write(8'h10, 32'd4);
    wb_write(8'h0C, 32'd200);
    for (int i = 0; i < 6; i++) wb_write(8'h04, 32'h400 + i);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled: irq=%b, required 0", irq);
    end
    wb_write(8'h08, 32'h1);
    repeat (3) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_level6: irq=%b, required 0", irq);
    end
    capture_frame(f, bn, ln, st);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_level5: irq=%b, required 0", irq);
    end
    capture_frame(f, bn, ln, st);
    checks++;
    if (irq !== IRQ_EN) begin
      errors++;
      $display("FAIL irq_level4: irq=%b, required %b", irq, IRQ_EN);
    end
    frame_check("irq_f2", f, 16'h3401, bn, ln);
    wb_write(8'h08, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_disable: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w;
    wb_write(8'h0C, 32'd20);
    wb_write(8'h08, 32'h1);
    w = 0;
    while (dac_cs_n !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy: busy=%b, required 1", busy);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, irq} !== 6'b100100) begin
      errors++;
      $display("FAIL mid_frame_reset: cs,sclk,sdi,ldac,busy,irq=%b, required 100100",
               {dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, irq});
    end
    read_check("mid_frame_status", 8'h00, 32'h0000_0002);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_overflow();
    test_back_to_back_late();
    test_irq();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
